npu: RTL and testbench



---
 rtl/npu.sv | 105 ++++++++++
 tb/tb_npu.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/npu.sv
// npu: sequential 3-element signed dot product, one multiply-accumulate per
// clock. Started by en in IDLE, signals completion with a single-cycle ack.
module npu #(
   parameter int data_size = 32,
   parameter int vec_len   = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [vec_len*data_size-1:0]  in1,
   input  logic [vec_len*data_size-1:0]  in2,
   output logic [data_size-1:0]          result,
   output logic                          busy,
   output logic                          ack
);

   localparam int IW = $clog2(vec_len);
   localparam logic [IW-1:0] LAST_IDX = IW'(vec_len - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MAC  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]                            state_q, state_d;
   logic [IW-1:0]                         idx_q, idx_d;
   logic [data_size-1:0]                  acc_q, acc_d;
   logic [data_size-1:0]                  result_q, result_d;
   logic [vec_len-1:0][data_size-1:0]     a_q, a_d;
   logic [vec_len-1:0][data_size-1:0]     b_q, b_d;

   logic [data_size-1:0]                  a_sel, b_sel;
   logic [data_size-1:0]                  prod_lo;
   logic [data_size-1:0]                  sum;

   // Datapath: select the current element pair and form the running sum.
   // The low data_size bits of a two's-complement product do not depend on
   // operand signedness, so a width-truncated multiply gives the signed
   // product modulo 2^data_size directly.
   always_comb begin
      a_sel   = a_q[idx_q];
      b_sel   = b_q[idx_q];
      prod_lo = a_sel * b_sel;
      sum     = acc_q + prod_lo;
   end

   // Next-state logic: capture operands on start, one MAC per cycle, publish
   // the final sum on the last element and spend one cycle in DONE for ack.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      result_d = result_q;
      a_d      = a_q;
      b_d      = b_q;
      case (state_q)
         IDLE: begin
            if (en) begin
               a_d     = in1;
               b_d     = in2;
               acc_d   = '0;
               idx_d   = '0;
               state_d = MAC;
            end
         end
         MAC: begin
            acc_d = sum;
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               result_d = sum;
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset clears everything and aborts any computation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         a_q      <= a_d;
         b_q      <= b_d;
      end
   end

   assign result = result_q;
   assign busy   = (state_q == MAC);
   assign ack    = (state_q == DONE);

endmodule

// File: tb/tb_npu.sv
// Self-checking bench for npu: table of known vectors, randomized vectors
// against an arithmetic reference, and hand-written multi-cycle sequences.
module tb_npu;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [95:0] in1;
   logic [95:0] in2;
   logic [31:0] result;
   logic        busy;
   logic        ack;

   int checks = 0;
   int errors = 0;
   logic [31:0] prev_result;

   typedef struct {
      string       name;
      logic [95:0] a;
      logic [95:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[4];

   npu #(.data_size(32), .vec_len(3)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .in1    (in1),
      .in2    (in2),
      .result (result),
      .busy   (busy),
      .ack    (ack)
   );

   always #5 clk = ~clk;

   function automatic logic [95:0] pk(input logic [31:0] e0, input logic [31:0] e1,
                                      input logic [31:0] e2);
      return {e2, e1, e0};
   endfunction

   // Reference: sum of full signed products, reduced modulo 2^32.
   function automatic logic [31:0] ref_dot(input logic [95:0] a, input logic [95:0] b);
      longint s;
      logic [31:0] ai, bi;
      s = 0;
      for (int i = 0; i < 3; i++) begin
         ai = a[32*i +: 32];
         bi = b[32*i +: 32];
         s = s + longint'($signed(ai)) * longint'($signed(bi));
      end
      return s[31:0];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full operation with timing checks; optionally zero the inputs right
   // after the start edge to show they are not re-sampled.
   task automatic do_op(input string nm, input logic [95:0] a, input logic [95:0] b,
                        input logic [31:0] exp, input bit scramble);
      in1 = a;
      in2 = b;
      en  = 1'b1;
      step();                       // start edge E
      en = 1'b0;
      if (scramble) begin
         in1 = '0;
         in2 = '0;
      end
      for (int c = 0; c < 3; c++) begin
         chk({nm, " busy"}, 32'(busy), 32'd1);
         chk({nm, " ack early"}, 32'(ack), 32'd0);
         chk({nm, " result held"}, result, prev_result);
         step();                    // edges E+1, E+2, E+3
      end
      chk({nm, " ack"}, 32'(ack), 32'd1);
      chk({nm, " busy at ack"}, 32'(busy), 32'd0);
      chk({nm, " result"}, result, exp);
      step();                       // edge E+4
      chk({nm, " ack cleared"}, 32'(ack), 32'd0);
      chk({nm, " result stable"}, result, exp);
      prev_result = exp;
      $display("op %s: result=0x%08h expected=0x%08h", nm, result, exp);
   endtask

   initial begin
      logic [95:0] ra, rb;

      tbl[0] = '{"basic",   pk(1, 2, 3), pk(4, 5, 6), 32'd32};
      tbl[1] = '{"signed",  pk(-32'sd2, 3, 32'h7FFF_FFFF), pk(5, -32'sd4, 2), 32'hFFFF_FFE8};
      tbl[2] = '{"trunc",   pk(32'h1_0000, 0, 0), pk(32'h1_0000, 0, 0), 32'd0};
      tbl[3] = '{"neg",     pk(-32'sd1, -32'sd1, -32'sd1), pk(-32'sd7, 3, 0), 32'd4};

      rst = 1'b1;
      en  = 1'b1;
      in1 = pk(1, 2, 3);
      in2 = pk(4, 5, 6);
      prev_result = 32'd0;

      // Reset held two cycles with en high: nothing starts.
      for (int c = 0; c < 2; c++) begin
         step();
         chk("reset ack", 32'(ack), 32'd0);
         chk("reset busy", 32'(busy), 32'd0);
         chk("reset result", result, 32'd0);
      end
      rst = 1'b0;
      en  = 1'b0;
      step();
      chk("post-reset idle busy", 32'(busy), 32'd0);
      $display("op reset: busy=%0d ack=%0d result=0x%08h", busy, ack, result);

      // Table-driven vectors.
      for (int i = 0; i < 4; i++)
         do_op(tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0);

      // Randomized vectors against the reference model.
      for (int i = 0; i < 8; i++) begin
         ra = {$urandom(), $urandom(), $urandom()};
         rb = {$urandom(), $urandom(), $urandom()};
         if (i < 3) begin
            ra = {{16'h0, ra[79:64]}, {24'h0, ra[39:32]}, {20'h0, ra[11:0]}};
         end
         do_op("random", ra, rb, ref_dot(ra, rb), 1'b0);
      end

      // Inputs changed right after start.
      do_op("input change", pk(1, 2, 3), pk(4, 5, 6), 32'd32, 1'b1);

      // Continuous en: ack every 5 cycles, never together with busy.
      in1 = pk(1, 1, 1);
      in2 = pk(2, 2, 2);
      en  = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         chk("cont ack timing", 32'(ack), 32'((c % 5) == 4));
         chk("cont busy/ack overlap", 32'(busy & ack), 32'd0);
         if ((c % 5) == 4)
            chk("cont result", result, 32'd6);
      end
      en = 1'b0;
      step();
      step();
      prev_result = 32'd6;
      $display("op continuous: last result=0x%08h", result);

      // Reset mid-operation: no ack, result cleared.
      in1 = pk(1, 2, 3);
      in2 = pk(4, 5, 6);
      en  = 1'b1;
      step();
      en = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk("abort ack", 32'(ack), 32'd0);
         chk("abort busy", 32'(busy), 32'd0);
         chk("abort result", result, 32'd0);
         step();
      end
      prev_result = 32'd0;
      $display("op abort: result=0x%08h", result);
      do_op("after abort", pk(1, 2, 3), pk(4, 5, 6), 32'd32, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
